spdif_sample_feeder: RTL and testbench
======================================

Name: spdif_sample_feeder

Overview:
Upstream stage of spdif_frame_encoder. Accepts stereo sample pairs over a valid/ready handshake and buffers them in a small FIFO. Serializes each pair as left then right onto the encoder's sample interface. Generates the IEC 60958-3 consumer channel-status bit (i_control) and user bit (i_user) for each sub-frame, indexed by the encoder's sub_frame_number.

Parameters:
audio_width, 24, sample width; must match spdif_frame_encoder.audio_width.
fifo_depth, 4, stereo pairs buffered; power of two, >= 2.

Ports:
clk128  in  1  128*fs clock
reset  in  1  asynchronous, active-high
s_valid  in  1  upstream pair valid
s_ready  out  1  upstream pair ready
s_left  in  audio_width  left sample
s_right  in  audio_width  right sample
cs_copy_permit  in  1  channel-status bit 2
cs_pre_emphasis  in  1  1 = 50/15 us; sets bits 3..5 to 001
cs_category  in  8  channel-status bits 8..15
cs_sample_rate  in  4  channel-status bits 24..27
cs_word_length  in  4  channel-status bits 32..35
sub_frame_number  in  9  from encoder, 0..383
o_valid  out  1  to encoder i_valid
o_ready  in  1  from encoder i_ready
o_is_left  out  1  to encoder i_is_left
o_audio  out  audio_width  to encoder i_audio
o_user  out  1  to encoder i_user
o_control  out  1  to encoder i_control
fifo_level  out  $clog2(fifo_depth)+1  stored pair count
underrun_count  out  16  saturating starvation counter

Behaviour:
- Clocking: single clock domain, clk128. All state resets asynchronously on reset.
- Reset values: s_ready=1, o_valid=0, o_is_left=1, o_audio=0, o_user=0, o_control=0, fifo_level=0, underrun_count=0, FSM=LEFT, channel-status shadow=0.
- Input side:
  - s_ready = !full (registered full flag). Push on s_valid && s_ready.
  - A push while full is impossible. A push and a pop in the same cycle leave the level unchanged.
- FIFO: synchronous pointers, entry width 2*audio_width. fifo_level is exact after every cycle.
- Output FSM has two states.
  - LEFT: o_valid = !empty; o_is_left=1; o_audio = head.left. On o_valid && o_ready -> RIGHT, no pop.
  - RIGHT: o_valid=1; o_is_left=0; o_audio = head.right. On o_ready -> pop head, go to LEFT.
  - o_audio, o_valid and o_is_left are combinational from FSM state and FIFO head.
- Latency: a pair pushed into an empty FIFO at edge N presents o_valid=1 (left) in the cycle after edge N.
- Reset mid-pair (in RIGHT) discards the pair and returns to LEFT with an empty FIFO.
- o_user = 0 always.
- Channel-status shadow (40 bits, bits 36..191 = 0):
  - Contents: bit0=0 (consumer), bit1=0 (PCM), bit2=cs_copy_permit, bits3..5 = {0,0,cs_pre_emphasis} (bit3 = cs_pre_emphasis), bits6..7=0, bits8..15=cs_category (bit8 = LSB), bits16..23=0 (source/channel unspecified), bits24..27=cs_sample_rate, bits28..31=0, bits32..35=cs_word_length.
  - Shadow loads from the cs_* inputs on every cycle where sub_frame_number==0 and !(o_valid && o_ready). It is frozen otherwise, so it is stable for a whole 192-frame block.
- o_control = shadow[sub_frame_number[8:1]]. It is combinational, identical for both sub-frames of a frame, and 0 for index >= 36.
- Underrun handling:
  - Condition: FSM=LEFT, FIFO empty, o_ready=1.
  - A starved flag sets on the first cycle of this condition, and underrun_count increments once (saturating at 16'hFFFF).
  - The flag clears on the next output handshake. underrun_count counts starvation episodes, not cycles.
- sub_frame_number wrap 383->0 needs no special handling beyond the shadow load rule.

Test Plan:
- Reset, then push L=24'h123456, R=24'hABCDEF with o_ready=1 -> o_valid rises the next cycle with o_is_left=1 and o_audio=24'h123456. After the handshake, o_is_left=0 and o_audio=24'hABCDEF. After the second handshake fifo_level returns to 0.
- Hold o_ready=0 and push 5 pairs at fifo_depth=4 -> 4 pairs are accepted, s_ready=0 after the fourth, fifo_level=4. Release o_ready -> pairs emerge in order L0,R0..L3,R3, and s_ready reasserts after the first pop.
- Sweep sub_frame_number 0..383 with cs_copy_permit=1, cs_pre_emphasis=0, cs_category=8'h01, cs_sample_rate=4'h2, cs_word_length=4'hB -> o_control=1 only at frame indices 2, 8, 25, 32, 33, 35.
- Change cs_category while sub_frame_number=50 -> o_control is unchanged until sub_frame_number returns to 0 and idles. The new value appears in the next block.
- Drain the FIFO with o_ready=1 held for 10 idle cycles, then push one pair -> underrun_count=1 (not 10). A second starvation after that pair gives underrun_count=2.
- Assert reset while in RIGHT with 2 pairs stored -> next cycle o_valid=0, fifo_level=0, o_is_left=1, s_ready=1.

Source files
------------

// File: rtl/spdif_sample_feeder.sv
// spdif_sample_feeder: buffers stereo pairs and feeds spdif_frame_encoder
// one sub-frame at a time. It also supplies the channel-status and user bits.
//
// Ports:
//   clk128, reset         128*fs clock, async active-high reset
//   s_valid/s_ready       upstream pair handshake (s_left, s_right)
//   cs_*                  consumer channel-status fields
//   sub_frame_number      encoder sub-frame index 0..383
//   o_valid/o_ready       encoder sample handshake (o_is_left, o_audio)
//   o_user, o_control     user bit and channel-status bit for the sub-frame
//   fifo_level            stored pair count
//   underrun_count        saturating count of starvation episodes
module spdif_sample_feeder #(
    parameter int audio_width = 24,
    parameter int fifo_depth  = 4
) (
    input  logic                          clk128,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [audio_width-1:0]        s_left,
    input  logic [audio_width-1:0]        s_right,
    input  logic                          cs_copy_permit,
    input  logic                          cs_pre_emphasis,
    input  logic [7:0]                    cs_category,
    input  logic [3:0]                    cs_sample_rate,
    input  logic [3:0]                    cs_word_length,
    input  logic [8:0]                    sub_frame_number,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic                          o_is_left,
    output logic [audio_width-1:0]        o_audio,
    output logic                          o_user,
    output logic                          o_control,
    output logic [$clog2(fifo_depth):0]   fifo_level,
    output logic [15:0]                   underrun_count
);

    localparam int AW = $clog2(fifo_depth);
    localparam int LW = AW + 1;
    localparam int EW = 2 * audio_width;

    typedef enum logic {
        ST_LEFT  = 1'b0,
        ST_RIGHT = 1'b1
    } state_t;

    state_t                 r_state;
    logic [EW-1:0]          r_mem [fifo_depth];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   r_full;
    logic [39:0]            r_cs;
    logic                   r_starved;
    logic [15:0]            r_underrun;

    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_hs;
    logic                   w_starve;
    logic                   w_cs_load;
    logic [LW-1:0]          w_level_nxt;
    logic [EW-1:0]          w_head;
    logic [audio_width-1:0] w_head_left;
    logic [audio_width-1:0] w_head_right;
    logic [39:0]            w_cs_next;
    logic [7:0]             w_idx;

    // ---------------- FIFO ----------------
    assign w_empty      = (r_level == '0);
    assign s_ready      = !r_full;
    assign w_push       = s_valid && !r_full;
    assign w_pop        = (r_state == ST_RIGHT) && o_ready;
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_left  = w_head[EW-1:audio_width];
    assign w_head_right = w_head[audio_width-1:0];
    assign fifo_level   = r_level;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + LW'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - LW'(1);
        end
    end

    // Storage is not reset; reads are gated by the level counter.
    always_ff @(posedge clk128) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_left, s_right};
        end
    end

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LW'(fifo_depth));
        end
    end

    // ---------------- output FSM ----------------
    // The pair stays at the head until its right half is accepted.
    always_comb begin
        o_valid   = 1'b0;
        o_is_left = 1'b1;
        o_audio   = '0;
        unique case (r_state)
            ST_LEFT: begin
                o_valid   = !w_empty;
                o_is_left = 1'b1;
                o_audio   = w_empty ? '0 : w_head_left;
            end
            ST_RIGHT: begin
                o_valid   = 1'b1;
                o_is_left = 1'b0;
                o_audio   = w_head_right;
            end
            default: begin
                o_valid   = 1'b0;
                o_is_left = 1'b1;
                o_audio   = '0;
            end
        endcase
    end

    assign w_hs = o_valid && o_ready;

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            r_state <= ST_LEFT;
        end else begin
            unique case (r_state)
                ST_LEFT:  if (w_hs)    r_state <= ST_RIGHT;
                ST_RIGHT: if (o_ready) r_state <= ST_LEFT;
                default:               r_state <= ST_LEFT;
            endcase
        end
    end

    // ---------------- channel status ----------------
    always_comb begin
        w_cs_next        = '0;
        w_cs_next[2]     = cs_copy_permit;
        w_cs_next[3]     = cs_pre_emphasis;
        w_cs_next[15:8]  = cs_category;
        w_cs_next[27:24] = cs_sample_rate;
        w_cs_next[35:32] = cs_word_length;
    end

    // Reload only at block start while no sub-frame is being consumed,
    // so the whole 192-frame block sees one consistent word.
    assign w_cs_load = (sub_frame_number == 9'd0) && !w_hs;

    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            r_cs <= '0;
        end else if (w_cs_load) begin
            r_cs <= w_cs_next;
        end
    end

    // Both sub-frames of a frame carry the same channel-status bit.
    assign w_idx     = sub_frame_number[8:1];
    assign o_control = (w_idx < 8'd36) ? r_cs[w_idx[5:0]] : 1'b0;
    assign o_user    = 1'b0;

    // ---------------- underrun ----------------
    assign w_starve       = (r_state == ST_LEFT) && w_empty && o_ready;
    assign underrun_count = r_underrun;

    // One count per starvation episode; the next handshake re-arms it.
    always_ff @(posedge clk128 or posedge reset) begin
        if (reset) begin
            r_starved  <= 1'b0;
            r_underrun <= '0;
        end else if (w_hs) begin
            r_starved <= 1'b0;
        end else if (w_starve && !r_starved) begin
            r_starved <= 1'b1;
            if (r_underrun != 16'hFFFF) begin
                r_underrun <= r_underrun + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_spdif_sample_feeder.sv
// Directed bench for spdif_sample_feeder: handshake, FIFO ordering,
// channel-status sweep and freeze, underrun episodes, mid-pair reset.
module tb_spdif_sample_feeder;

    logic        clk128 = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        cs_copy_permit;
    logic        cs_pre_emphasis;
    logic [7:0]  cs_category;
    logic [3:0]  cs_sample_rate;
    logic [3:0]  cs_word_length;
    logic [8:0]  sub_frame_number;
    logic        o_valid;
    logic        o_ready;
    logic        o_is_left;
    logic [23:0] o_audio;
    logic        o_user;
    logic        o_control;
    logic [2:0]  fifo_level;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    spdif_sample_feeder #(.audio_width(24), .fifo_depth(4)) dut (
        .clk128           (clk128),
        .reset            (reset),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_left           (s_left),
        .s_right          (s_right),
        .cs_copy_permit   (cs_copy_permit),
        .cs_pre_emphasis  (cs_pre_emphasis),
        .cs_category      (cs_category),
        .cs_sample_rate   (cs_sample_rate),
        .cs_word_length   (cs_word_length),
        .sub_frame_number (sub_frame_number),
        .o_valid          (o_valid),
        .o_ready          (o_ready),
        .o_is_left        (o_is_left),
        .o_audio          (o_audio),
        .o_user           (o_user),
        .o_control        (o_control),
        .fifo_level       (fifo_level),
        .underrun_count   (underrun_count)
    );

    always #5 clk128 = ~clk128;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk128);
        #1;
    endtask

    initial begin
        logic exp_ctl;
        int   idx;

        reset            = 1'b1;
        s_valid          = 1'b0;
        s_left           = '0;
        s_right          = '0;
        cs_copy_permit   = 1'b0;
        cs_pre_emphasis  = 1'b0;
        cs_category      = '0;
        cs_sample_rate   = '0;
        cs_word_length   = '0;
        sub_frame_number = '0;
        o_ready          = 1'b0;
        cyc();
        cyc();

        // reset state
        chk("rst_s_ready", s_ready, 1);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_is_left", o_is_left, 1);
        chk("rst_audio", o_audio, 0);
        chk("rst_user", o_user, 0);
        chk("rst_control", o_control, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_underrun", underrun_count, 0);
        reset = 1'b0;
        cyc();

        // single pair through
        s_valid = 1'b1;
        s_left  = 24'h123456;
        s_right = 24'hABCDEF;
        cyc();
        s_valid = 1'b0;
        chk("t1_valid", o_valid, 1);
        chk("t1_is_left", o_is_left, 1);
        chk("t1_left", o_audio, 24'h123456);
        chk("t1_level", fifo_level, 1);
        o_ready = 1'b1;
        cyc();
        chk("t1_r_valid", o_valid, 1);
        chk("t1_r_is_left", o_is_left, 0);
        chk("t1_right", o_audio, 24'hABCDEF);
        cyc();
        o_ready = 1'b0;
        chk("t1_level0", fifo_level, 0);
        chk("t1_valid0", o_valid, 0);
        chk("t1_underrun", underrun_count, 0);

        // fill past capacity with the encoder stalled
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_left  = 24'h100000 + 24'(i);
            s_right = 24'h200000 + 24'(i);
            cyc();
            if (i == 3) chk("t2_full_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        chk("t2_level4", fifo_level, 4);
        chk("t2_ready_hold", s_ready, 0);

        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_l_valid", o_valid, 1);
            chk("t2_l_is_left", o_is_left, 1);
            chk("t2_l_audio", o_audio, 24'h100000 + 24'(i));
            cyc();
            chk("t2_r_is_left", o_is_left, 0);
            chk("t2_r_audio", o_audio, 24'h200000 + 24'(i));
            cyc();
            if (i == 3) o_ready = 1'b0;
            if (i == 0) begin
                chk("t2_ready_back", s_ready, 1);
                chk("t2_level3", fifo_level, 3);
            end
        end
        chk("t2_level0", fifo_level, 0);
        chk("t2_valid0", o_valid, 0);
        chk("t2_underrun", underrun_count, 0);

        // channel-status sweep
        cs_copy_permit   = 1'b1;
        cs_pre_emphasis  = 1'b0;
        cs_category      = 8'h01;
        cs_sample_rate   = 4'h2;
        cs_word_length   = 4'hB;
        sub_frame_number = 9'd0;
        cyc();
        for (int n = 0; n < 384; n++) begin
            sub_frame_number = 9'(n);
            #1;
            idx     = n / 2;
            exp_ctl = (idx == 2) || (idx == 8) || (idx == 25) ||
                      (idx == 32) || (idx == 33) || (idx == 35);
            chk("t3_control", o_control, exp_ctl);
            cyc();
        end

        // category change mid-block stays frozen until block start
        sub_frame_number = 9'd50;
        cs_category      = 8'h80;
        cyc();
        cyc();
        sub_frame_number = 9'd16;
        #1;
        chk("t4_old_bit8", o_control, 1);
        sub_frame_number = 9'd30;
        #1;
        chk("t4_old_bit15", o_control, 0);
        cyc();
        sub_frame_number = 9'd0;
        cyc();
        sub_frame_number = 9'd16;
        #1;
        chk("t4_new_bit8", o_control, 0);
        sub_frame_number = 9'd30;
        #1;
        chk("t4_new_bit15", o_control, 1);
        sub_frame_number = 9'd0;
        cyc();

        // underrun episodes
        o_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("t5_episode1", underrun_count, 1);
        s_valid = 1'b1;
        s_left  = 24'h0000AA;
        s_right = 24'h0000BB;
        cyc();
        s_valid = 1'b0;
        chk("t5_left", o_audio, 24'h0000AA);
        cyc();
        chk("t5_right", o_audio, 24'h0000BB);
        cyc();
        chk("t5_still1", underrun_count, 1);
        cyc();
        cyc();
        chk("t5_episode2", underrun_count, 2);
        o_ready = 1'b0;
        cyc();

        // reset while mid-pair
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_left  = 24'h300000 + 24'(i);
            s_right = 24'h400000 + 24'(i);
            cyc();
        end
        s_valid = 1'b0;
        o_ready = 1'b1;
        cyc();
        o_ready = 1'b0;
        chk("t6_in_right", o_is_left, 0);
        chk("t6_level2", fifo_level, 2);
        reset = 1'b1;
        cyc();
        chk("t6_valid", o_valid, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_is_left", o_is_left, 1);
        chk("t6_s_ready", s_ready, 1);
        chk("t6_underrun", underrun_count, 0);
        reset = 1'b0;
        cyc();
        chk("t6_post_valid", o_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
